// File: rtl/frame_buf_sched.sv
// Multi-region frame-buffer scheduler: hands DDR frame regions to writer and reader so the display never shows a partial frame.
// Optional drop/repeat statistics are built when FRAME_SCHED_STATS_EN is defined; otherwise both counters read as zero.
module frame_buf_sched #(
  parameter int unsigned NUM_FRAMES = 3,
  parameter int unsigned FRAME_SIZE = 'd1228800,
  parameter int unsigned FRAME_BASE = 'd0,
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              ui_clk,
  input  logic              ui_rst,
  input  logic              wr_frame_done,
  input  logic              rd_frame_start,
  input  logic              rd_freeze,
  output logic [2:0]        wr_idx,
  output logic [2:0]        rd_idx,
  output logic [ADDR_W-1:0] wr_beg_addr,
  output logic [ADDR_W-1:0] wr_end_addr,
  output logic [ADDR_W-1:0] rd_beg_addr,
  output logic [ADDR_W-1:0] rd_end_addr,
  output logic              rd_frame_ok,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  repeat_cnt
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {S_EMPTY, S_READY, S_RUN} state_t;

  function automatic logic [ADDR_W-1:0] beg_of(input logic [IDX_W-1:0] idx);
    return ADDR_W'(FRAME_BASE) + ADDR_W'(idx) * ADDR_W'(FRAME_SIZE);
  endfunction

  function automatic logic [ADDR_W-1:0] end_of(input logic [IDX_W-1:0] idx);
    return beg_of(idx) + ADDR_W'(FRAME_SIZE - 1);
  endfunction

  state_t           r_state;
  logic [IDX_W-1:0] r_w;
  logic [IDX_W-1:0] r_r;
  logic [IDX_W-1:0] r_l;
  logic             r_fresh;
  logic             r_rd_ok;
  logic [ADDR_W-1:0] r_wr_beg, r_wr_end, r_rd_beg, r_rd_end;

  logic             w_switch;
  logic             w_fresh_rd;
  logic [IDX_W-1:0] w_r_nxt;
  logic [IDX_W-1:0] w_w_nxt;
  logic [IDX_W-1:0] w_l_nxt;
  logic             w_fresh_nxt;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Read event is resolved first; the write event then sees the updated reader region.
  assign w_switch   = rd_frame_start && r_fresh && !rd_freeze;
  assign w_fresh_rd = r_fresh && !w_switch;
  assign w_r_nxt    = w_switch ? r_l : r_r;

  always_comb begin
    w_w_nxt     = r_w;
    w_l_nxt     = r_l;
    w_fresh_nxt = w_fresh_rd;
    w_cand      = '0;
    w_found     = 1'b0;
    if (wr_frame_done) begin
      w_l_nxt     = r_w;
      w_fresh_nxt = 1'b1;
      // Round-robin from w+1, skipping the reader's region and the frame just completed.
      for (int unsigned k = 1; k < NUM_FRAMES; k++) begin
        w_cand = IDX_W'((32'(r_w) + k) % NUM_FRAMES);
        if (!w_found && (w_cand != w_r_nxt) && (w_cand != r_w)) begin
          w_w_nxt = w_cand;
          w_found = 1'b1;
        end
      end
    end
  end

  // Index, address and FSM registers; addresses track the next indices so they move together.
  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      r_state  <= S_EMPTY;
      r_w      <= '0;
      r_r      <= IDX_W'(NUM_FRAMES - 1);
      r_l      <= '0;
      r_fresh  <= 1'b0;
      r_rd_ok  <= 1'b0;
      r_wr_beg <= beg_of('0);
      r_wr_end <= end_of('0);
      r_rd_beg <= beg_of(IDX_W'(NUM_FRAMES - 1));
      r_rd_end <= end_of(IDX_W'(NUM_FRAMES - 1));
    end else begin
      r_w      <= w_w_nxt;
      r_r      <= w_r_nxt;
      r_l      <= w_l_nxt;
      r_fresh  <= w_fresh_nxt;
      r_wr_beg <= beg_of(w_w_nxt);
      r_wr_end <= end_of(w_w_nxt);
      r_rd_beg <= beg_of(w_r_nxt);
      r_rd_end <= end_of(w_r_nxt);
      case (r_state)
        S_EMPTY: begin
          r_rd_ok <= 1'b0;
          if (wr_frame_done) r_state <= S_READY;
        end
        S_READY: begin
          r_rd_ok <= w_switch;
          if (w_switch) r_state <= S_RUN;
        end
        S_RUN: begin
          r_rd_ok <= 1'b1;
        end
        default: begin
          r_state <= S_EMPTY;
          r_rd_ok <= 1'b0;
        end
      endcase
    end
  end

  assign wr_idx      = r_w;
  assign rd_idx      = r_r;
  assign wr_beg_addr = r_wr_beg;
  assign wr_end_addr = r_wr_end;
  assign rd_beg_addr = r_rd_beg;
  assign rd_end_addr = r_rd_end;
  assign rd_frame_ok = r_rd_ok;

`ifdef FRAME_SCHED_STATS_EN
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_repeat_cnt;

  // Saturating statistics; a repeat is a reader start that could not switch, ignored before any frame exists.
  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      r_drop_cnt   <= '0;
      r_repeat_cnt <= '0;
    end else begin
      if (wr_frame_done && w_fresh_rd && (r_drop_cnt != {CNT_W{1'b1}}))
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      if (rd_frame_start && !w_switch && (r_state != S_EMPTY) &&
          (r_repeat_cnt != {CNT_W{1'b1}}))
        r_repeat_cnt <= r_repeat_cnt + CNT_W'(1);
    end
  end

  assign drop_cnt   = r_drop_cnt;
  assign repeat_cnt = r_repeat_cnt;
`else
  assign drop_cnt   = '0;
  assign repeat_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed bench for frame_buf_sched with NUM_FRAMES=3, FRAME_SIZE=100, plus a random-pulse region-overlap soak.
module tb_frame_buf_sched;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned CNT_W  = 16;
`ifdef FRAME_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              ui_clk = 1'b0;
  logic              ui_rst = 1'b1;
  logic              wr_frame_done = 1'b0;
  logic              rd_frame_start = 1'b0;
  logic              rd_freeze = 1'b0;
  logic [2:0]        wr_idx, rd_idx;
  logic [ADDR_W-1:0] wr_beg_addr, wr_end_addr, rd_beg_addr, rd_end_addr;
  logic              rd_frame_ok;
  logic [CNT_W-1:0]  drop_cnt, repeat_cnt;

  int checks   = 0;
  int failures = 0;

  frame_buf_sched #(
    .NUM_FRAMES(3), .FRAME_SIZE(100), .FRAME_BASE(0), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .ui_clk(ui_clk), .ui_rst(ui_rst),
    .wr_frame_done(wr_frame_done), .rd_frame_start(rd_frame_start), .rd_freeze(rd_freeze),
    .wr_idx(wr_idx), .rd_idx(rd_idx),
    .wr_beg_addr(wr_beg_addr), .wr_end_addr(wr_end_addr),
    .rd_beg_addr(rd_beg_addr), .rd_end_addr(rd_end_addr),
    .rd_frame_ok(rd_frame_ok), .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
  );

  always #5 ui_clk = ~ui_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  // Check every output against a hand-computed state.
  task automatic check_all(input string tag, input int widx, input int ridx, input bit ok,
                           input int drops, input int reps);
    check({tag, ".wr_idx"}, 32'(wr_idx), 32'(widx));
    check({tag, ".wr_beg"}, 32'(wr_beg_addr), 32'(widx * 100));
    check({tag, ".wr_end"}, 32'(wr_end_addr), 32'(widx * 100 + 99));
    check({tag, ".rd_idx"}, 32'(rd_idx), 32'(ridx));
    check({tag, ".rd_beg"}, 32'(rd_beg_addr), 32'(ridx * 100));
    check({tag, ".rd_end"}, 32'(rd_end_addr), 32'(ridx * 100 + 99));
    check({tag, ".rd_ok"}, 32'(rd_frame_ok), 32'(ok));
    check({tag, ".drop"}, 32'(drop_cnt), cnt_exp(drops));
    check({tag, ".repeat"}, 32'(repeat_cnt), cnt_exp(reps));
  endtask

  // One-cycle pulse of the given inputs; returns at the next negedge, after the capturing edge.
  task automatic step(input bit wr, input bit rd, input bit frz);
    @(negedge ui_clk);
    wr_frame_done  = wr;
    rd_frame_start = rd;
    rd_freeze      = frz;
    @(negedge ui_clk);
    wr_frame_done  = 1'b0;
    rd_frame_start = 1'b0;
    rd_freeze      = 1'b0;
  endtask

  initial begin
    int overlap;
    ui_rst = 1'b1;
    repeat (3) @(negedge ui_clk);
    ui_rst = 1'b0;
    check_all("reset", 0, 2, 1'b0, 0, 0);

    // Reader start before any frame: no switch, no repeat counted.
    step(1'b0, 1'b1, 1'b0);
    check_all("empty_rd", 0, 2, 1'b0, 0, 0);

    // First frame: l=0, w=1.
    step(1'b1, 1'b0, 1'b0);
    check_all("first_wr", 1, 2, 1'b0, 0, 0);

    // Reader picks up frame 0 and the FSM enters run.
    step(1'b0, 1'b1, 1'b0);
    check_all("first_rd", 1, 0, 1'b1, 0, 0);

    // Repeat with no fresh frame.
    step(1'b0, 1'b1, 1'b0);
    check_all("repeat0", 1, 0, 1'b1, 0, 1);

    // Two writes with no read: l=1,w=2 then l=2,w=1 with one drop.
    step(1'b1, 1'b0, 1'b0);
    check_all("drop_a", 2, 0, 1'b1, 0, 1);
    step(1'b1, 1'b0, 1'b0);
    check_all("drop_b", 1, 0, 1'b1, 1, 1);

    // Frozen reader keeps region 0; frame 2 stays fresh.
    step(1'b0, 1'b1, 1'b1);
    check_all("freeze", 1, 0, 1'b1, 1, 2);

    // Simultaneous events from r=0,w=1,l=2,fresh=1: r=2, then l=1, w=0, no drop.
    step(1'b1, 1'b1, 1'b0);
    check_all("simul", 0, 2, 1'b1, 1, 2);

    // Frame 1 is still fresh: reader switches to it, proving l=1 and fresh=1.
    step(1'b0, 1'b1, 1'b0);
    check_all("after_simul", 0, 1, 1'b1, 1, 2);

    // Back-to-back writes on consecutive cycles: l=0,w=2 then drop, l=2,w=0.
    @(negedge ui_clk);
    wr_frame_done = 1'b1;
    @(negedge ui_clk);
    check_all("b2b_a", 2, 1, 1'b1, 1, 2);
    @(negedge ui_clk);
    wr_frame_done = 1'b0;
    check_all("b2b_b", 0, 1, 1'b1, 2, 2);

    // Reset mid-run restores reset values one cycle later.
    @(negedge ui_clk);
    ui_rst = 1'b1;
    @(negedge ui_clk);
    ui_rst = 1'b0;
    check_all("mid_reset", 0, 2, 1'b0, 0, 0);

    // Random pulse soak: the two regions must never coincide.
    overlap = 0;
    for (int i = 0; i < 4000; i++) begin
      wr_frame_done  = ($urandom_range(0, 2) == 0);
      rd_frame_start = ($urandom_range(0, 3) == 0);
      rd_freeze      = ($urandom_range(0, 7) == 0);
      @(negedge ui_clk);
      if (wr_idx == rd_idx || wr_idx > 3'd2 || rd_idx > 3'd2) overlap++;
      if (wr_beg_addr == rd_beg_addr) overlap++;
    end
    wr_frame_done  = 1'b0;
    rd_frame_start = 1'b0;
    rd_freeze      = 1'b0;
    check("soak_overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
